// File: rtl/game_state_controller.sv
// rtl/game_state_controller.sv - Frogger game-flow sequencer: idle, running, timed death freeze, game over.
module game_state_controller #(
    parameter int unsigned LIVES_INI         = 3,
    parameter int unsigned DEATH_HOLD_CYCLES = 25_000_000,
    parameter int unsigned MAX_LEVEL         = 9
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_Start,
    input  logic       i_Has_Collided,
    input  logic       i_Level_Up,
    output logic       o_Game_Active,
    output logic       o_Frog_Reset,
    output logic [2:0] o_Lives,
    output logic [3:0] o_Level,
    output logic       o_Game_Over,
    output logic [1:0] o_State
);

    localparam int unsigned       HOLD_W     = $clog2(DEATH_HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LOAD  = HOLD_W'(DEATH_HOLD_CYCLES - 1);
    localparam logic [2:0]        LIVES_LOAD = 3'(LIVES_INI);
    localparam logic [3:0]        LEVEL_MAX  = 4'(MAX_LEVEL);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_RUNNING   = 2'b01,
        ST_DEATH     = 2'b10,
        ST_GAME_OVER = 2'b11
    } state_e;

    state_e             state_q, state_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [2:0]         lives_q, lives_d;
    logic [3:0]         level_q, level_d;
    logic               frog_reset_q, frog_reset_d;
    logic               active_q, over_q;
    logic               start_prev_q;
    logic               start_edge;

    // start_prev_q resets high so switches held through reset cannot start a game.
    assign start_edge = i_Start & ~start_prev_q;

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        lives_d      = lives_q;
        level_d      = level_q;
        frog_reset_d = 1'b0;
        case (state_q)
            ST_IDLE, ST_GAME_OVER: begin
                if (start_edge) begin
                    state_d      = ST_RUNNING;
                    lives_d      = LIVES_LOAD;
                    level_d      = 4'd0;
                    frog_reset_d = 1'b1;
                end
            end
            ST_RUNNING: begin
                // A collision in the same cycle as a level-up wins; the level-up is lost.
                if (i_Has_Collided && (lives_q != 3'd0)) begin
                    state_d = ST_DEATH;
                    lives_d = lives_q - 3'd1;
                    hold_d  = HOLD_LOAD;
                end else if (i_Level_Up) begin
                    if (level_q < LEVEL_MAX) begin
                        level_d = level_q + 4'd1;
                    end
                    frog_reset_d = 1'b1;
                end
            end
            ST_DEATH: begin
                if (hold_q == '0) begin
                    if (lives_q == 3'd0) begin
                        state_d = ST_GAME_OVER;
                    end else begin
                        state_d      = ST_RUNNING;
                        frog_reset_d = 1'b1;
                    end
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state_q      <= ST_IDLE;
            hold_q       <= '0;
            lives_q      <= LIVES_LOAD;
            level_q      <= 4'd0;
            frog_reset_q <= 1'b0;
            active_q     <= 1'b0;
            over_q       <= 1'b0;
            start_prev_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            lives_q      <= lives_d;
            level_q      <= level_d;
            frog_reset_q <= frog_reset_d;
            active_q     <= (state_d == ST_RUNNING);
            over_q       <= (state_d == ST_GAME_OVER);
            start_prev_q <= i_Start;
        end
    end

    assign o_State       = state_q;
    assign o_Game_Active = active_q;
    assign o_Game_Over   = over_q;
    assign o_Frog_Reset  = frog_reset_q;
    assign o_Lives       = lives_q;
    assign o_Level       = level_q;

endmodule

// File: tb/tb_game_state_controller.sv
// tb/tb_game_state_controller.sv - scoreboard bench for game_state_controller with a 4-cycle death freeze.
module tb_game_state_controller;

    localparam logic [1:0] S_IDLE = 2'b00, S_RUN = 2'b01, S_DEATH = 2'b10, S_GO = 2'b11;

    logic       i_Clk = 1'b0;
    logic       i_Reset;
    logic       i_Start;
    logic       i_Has_Collided;
    logic       i_Level_Up;
    logic       o_Game_Active;
    logic       o_Frog_Reset;
    logic [2:0] o_Lives;
    logic [3:0] o_Level;
    logic       o_Game_Over;
    logic [1:0] o_State;

    typedef struct {
        logic [1:0] st;
        int         lives;
        int         level;
        logic       fr;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    game_state_controller #(
        .LIVES_INI(3),
        .DEATH_HOLD_CYCLES(4),
        .MAX_LEVEL(9)
    ) dut (
        .i_Clk(i_Clk),
        .i_Reset(i_Reset),
        .i_Start(i_Start),
        .i_Has_Collided(i_Has_Collided),
        .i_Level_Up(i_Level_Up),
        .o_Game_Active(o_Game_Active),
        .o_Frog_Reset(o_Frog_Reset),
        .o_Lives(o_Lives),
        .o_Level(o_Level),
        .o_Game_Over(o_Game_Over),
        .o_State(o_State)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [1:0] st, input int lives,
                             input int level, input logic fr);
        cmp({tag, " state"},  int'(o_State), int'(st));
        cmp({tag, " lives"},  int'(o_Lives), lives);
        cmp({tag, " level"},  int'(o_Level), level);
        cmp({tag, " frog_reset"}, int'(o_Frog_Reset), int'(fr));
        cmp({tag, " active"}, int'(o_Game_Active), int'(st == S_RUN));
        cmp({tag, " game_over"}, int'(o_Game_Over), int'(st == S_GO));
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic step(input logic s, input logic c, input logic l,
                        input logic [1:0] st, input int lives, input int level, input logic fr);
        exp_t e;
        @(negedge i_Clk);
        i_Start        = s;
        i_Has_Collided = c;
        i_Level_Up     = l;
        e.st = st; e.lives = lives; e.level = level; e.fr = fr;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge i_Clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_all("cycle", e.st, e.lives, e.level, e.fr);
            end
        end
    end

    initial begin : stimulus
        int lvl;
        i_Reset = 1'b1;
        i_Start = 1'b1;
        i_Has_Collided = 1'b0;
        i_Level_Up = 1'b0;
        #3;
        check_all("reset", S_IDLE, 3, 0, 1'b0);
        repeat (2) @(posedge i_Clk);
        @(negedge i_Clk);
        i_Reset = 1'b0;

        // Start held across reset must not start a game.
        step(1, 0, 0, S_IDLE, 3, 0, 0);
        step(1, 0, 0, S_IDLE, 3, 0, 0);
        step(0, 0, 0, S_IDLE, 3, 0, 0);
        step(1, 0, 0, S_RUN,  3, 0, 1);
        step(1, 0, 0, S_RUN,  3, 0, 0);

        // 12 level-ups: level saturates at 9, every pulse respawns the frog.
        for (int k = 1; k <= 12; k++) begin
            lvl = (k > 9) ? 9 : k;
            step(1, 0, 1, S_RUN, 3, lvl, 1);
            step(1, 0, 0, S_RUN, 3, lvl, 0);
        end

        // Three collisions; inputs during the freeze are ignored.
        for (int n = 2; n >= 0; n--) begin
            step(1, 1, 0, S_DEATH, n, 9, 0);
            step(1, 1, 1, S_DEATH, n, 9, 0);
            step(0, 0, 1, S_DEATH, n, 9, 0);
            step(1, 1, 0, S_DEATH, n, 9, 0);
            if (n > 0) begin
                step(1, 0, 0, S_RUN, n, 9, 1);
                step(1, 0, 0, S_RUN, n, 9, 0);
            end else begin
                step(1, 0, 0, S_GO, 0, 9, 0);
            end
        end
        step(1, 1, 1, S_GO, 0, 9, 0);
        step(0, 0, 0, S_GO, 0, 9, 0);
        step(1, 0, 0, S_RUN, 3, 0, 1);
        step(1, 0, 0, S_RUN, 3, 0, 0);

        // Reach level 2, then collision and level-up together.
        step(1, 0, 1, S_RUN, 3, 1, 1);
        step(1, 0, 0, S_RUN, 3, 1, 0);
        step(1, 0, 1, S_RUN, 3, 2, 1);
        step(1, 0, 0, S_RUN, 3, 2, 0);
        step(1, 1, 1, S_DEATH, 2, 2, 0);
        step(0, 0, 0, S_DEATH, 2, 2, 0);

        // Hold counter is now 2: asynchronous reset mid-cycle.
        @(posedge i_Clk);
        #3;
        i_Reset = 1'b1;
        #1;
        check_all("async_reset", S_IDLE, 3, 0, 1'b0);
        @(posedge i_Clk);
        @(negedge i_Clk);
        i_Reset = 1'b0;
        step(0, 0, 0, S_IDLE, 3, 0, 0);
        step(0, 0, 0, S_IDLE, 3, 0, 0);
        step(0, 0, 0, S_IDLE, 3, 0, 0);
        step(1, 0, 0, S_RUN,  3, 0, 1);
        step(0, 0, 0, S_RUN,  3, 0, 0);

        repeat (3) @(posedge i_Clk);
        #2;
        cmp("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
